// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end.
// Holds the instruction/address widths, the decoder field positions, the
// fetch FSM state type and the {instr, pc} queue entry layout.
package cpu_pkg;

   localparam int XLEN    = 32;           // instruction word width
   localparam int ADDR_W  = 32;           // byte address width
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int FC_MSB  = 5;
   localparam int FC_LSB  = 0;
   localparam int ENTRY_W = XLEN + ADDR_W;

   // IDLE: nothing outstanding, BUSY: live request outstanding,
   // DROP: request outstanding whose data must be thrown away
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]   instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched {instr, pc} entries.
// Ports: clk, rst (sync, active high), push/din write, pop advances the head,
//        flush empties the queue (priority over push/pop), head is the oldest
//        entry (combinational), count is the occupancy 0..DEPTH.
// The caller guarantees no push when full and no pop when empty.
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         // stale entries stay in storage; only the bookkeeping is cleared
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches to instruction memory, buffers
// up to two returned words with their PCs, and presents the head entry.
// Ports: clk, rst (sync, active high)
//        imem_req/imem_addr out, imem_ack/imem_rdata in (ack completes request)
//        stall (head held), redirect/redirect_pc (flush and restart)
//        instr_valid/instr/op/fc/pc_out/pc_plus4 describe the head entry.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [XLEN-1:0]   imem_rdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   output logic [XLEN-1:0]   instr,
   output logic [5:0]        op,
   output logic [5:0]        fc,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus4
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;         // next fetch address
   logic [ADDR_W-1:0] drop_addr;  // address of the killed request still on the bus
   logic [1:0]        count;
   fetch_entry_t      head_e;
   fetch_entry_t      push_e;
   logic              fire;
   logic              push;
   logic              pop;

   // A new fetch starts only with room in the queue; the redirect term keeps
   // a fetch of the stale PC from launching in the cycle the PC is replaced.
   assign imem_req  = !rst && ((state != IDLE) || (count < 2'd2 && !redirect));
   assign imem_addr = (state == DROP) ? drop_addr : pc;

   assign fire   = imem_req && imem_ack;
   assign push   = fire && (state != DROP) && !redirect;
   assign pop    = instr_valid && !stall && !redirect;
   assign push_e = '{instr: imem_rdata, pc: pc};

   fetch_queue #(.DEPTH(2), .WIDTH(ENTRY_W)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (push_e),
      .head  (head_e),
      .count (count)
   );

   // Head view is forced to zero while in reset, before the entries clear.
   assign instr_valid = !rst && (count != 2'd0);
   assign instr       = rst ? '0 : head_e.instr;
   assign pc_out      = rst ? '0 : head_e.pc;
   assign op          = instr[OP_MSB:OP_LSB];
   assign fc          = instr[FC_MSB:FC_LSB];
   assign pc_plus4    = pc_out + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         drop_addr <= '0;
      end else if (redirect) begin
         pc <= redirect_pc;
         case (state)
            BUSY: begin
               if (fire) state <= IDLE;
               else begin
                  // the bus still owes us this address; remember it so the
                  // request stays stable until its ack arrives
                  state     <= DROP;
                  drop_addr <= pc;
               end
            end
            DROP:    state <= fire ? IDLE : DROP;
            default: state <= IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (imem_req) begin
                  if (imem_ack) pc <= pc + 32'd4;
                  else          state <= BUSY;
               end
            end
            BUSY: begin
               if (imem_ack) begin
                  pc    <= pc + 32'd4;
                  state <= IDLE;
               end
            end
            DROP:    if (imem_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch. A transaction-level model (queue of
// fetched words, next PC, outstanding/killed flags) predicts the memory
// request and the head entry every cycle; a memory model with per-request
// latency answers the requests and sprinkles stray acks while req is low.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  fc;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;

   instr_fetch #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .op          (op),
      .fc          (fc),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model
   logic [31:0] m_pc = RST_PC;
   logic [63:0] m_q[$];            // {instr, pc}, oldest first
   bit          m_out  = 1'b0;     // a request is on the bus
   bit          m_kill = 1'b0;     // ... and its data is unwanted
   logic [31:0] m_kaddr = '0;

   // memory model
   bit mem_busy = 1'b0;
   int mem_left = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic step(input int lat_min, input int lat_max, input int stall_pct,
                       input int redir_pct, input int rst_pct);
      logic [31:0] r, e_addr, e_instr, e_pc;
      bit          e_req, e_valid, fire;
      @(negedge clk);
      rst      = ($urandom_range(99) < rst_pct);
      stall    = ($urandom_range(99) < stall_pct);
      redirect = ($urandom_range(99) < redir_pct);
      r = $urandom();
      case ($urandom_range(2))
         0:       redirect_pc = 32'h0000_0100;
         1:       redirect_pc = 32'hFFFF_FFFC;
         default: redirect_pc = {r[31:2], 2'b00};
      endcase
      #1;
      e_req  = !rst && (m_out || (m_q.size() < 2 && !redirect));
      e_addr = m_kill ? m_kaddr : m_pc;
      chk("req", {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) chk("addr", imem_addr, e_addr);

      e_valid = !rst && (m_q.size() > 0);
      chk("valid", {31'd0, instr_valid}, {31'd0, e_valid});
      if (e_valid) begin
         e_instr = m_q[0][63:32];
         e_pc    = m_q[0][31:0];
         chk("instr", instr, e_instr);
         chk("op", {26'd0, op}, e_instr >> 26);
         chk("fc", {26'd0, fc}, e_instr & 32'h3F);
         chk("pc_out", pc_out, e_pc);
         chk("pc_plus4", pc_plus4, e_pc + 32'd4);
      end else if (rst) begin
         chk("rst_instr", instr, 32'd0);
         chk("rst_op", {26'd0, op}, 32'd0);
         chk("rst_fc", {26'd0, fc}, 32'd0);
         chk("rst_pc_out", pc_out, 32'd0);
      end

      // memory answers after its drawn latency; stray acks while idle
      if (imem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_left = $urandom_range(lat_max, lat_min);
         end
         if (mem_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_busy   = 1'b0;
         end else begin
            mem_left--;
            imem_ack   = 1'b0;
            imem_rdata = $urandom();
         end
      end else begin
         mem_busy   = 1'b0;
         imem_ack   = ($urandom_range(3) == 0);
         imem_rdata = $urandom();
      end

      // advance the model to the state after the coming rising edge
      fire = e_req && imem_ack;
      if (rst) begin
         m_pc = RST_PC;
         m_q.delete();
         m_out  = 1'b0;
         m_kill = 1'b0;
      end else if (redirect) begin
         m_q.delete();
         if (m_out && !fire) begin
            if (!m_kill) m_kaddr = m_pc;
            m_kill = 1'b1;
         end else begin
            m_out  = 1'b0;
            m_kill = 1'b0;
         end
         m_pc = redirect_pc;
      end else begin
         if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
         if (fire) begin
            if (!m_kill) begin
               m_q.push_back({imem_rdata, m_pc});
               m_pc = m_pc + 32'd4;
            end
            m_out  = 1'b0;
            m_kill = 1'b0;
         end else if (e_req) begin
            m_out = 1'b1;
         end
      end
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      repeat (3)    step(0, 0, 0, 0, 100);  // reset state
      repeat (40)   step(0, 0, 0, 0, 0);    // zero-latency streaming
      repeat (40)   step(3, 3, 0, 0, 0);    // fixed latency 3
      repeat (60)   step(0, 1, 70, 0, 0);   // heavy stall, queue fills
      repeat (60)   step(0, 2, 20, 25, 0);  // frequent redirects
      repeat (2000) step(0, 3, 30, 10, 2);  // everything mixed
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
